// File: rtl/seven_seg_scan_if.sv
// Display-bank bus: packed digit data, masks and strobes in; the scanned
// segment, decimal-point and anode pins plus the frame pulse out.
interface seven_seg_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic [DIGITS-1:0]   dp_mask;
    logic [DIGITS-1:0]   blink_mask;
    logic                blank;
    logic                lz_en;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_done;

    modport master (
        output value, load, dp_mask, blink_mask, blank, lz_en,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  value, load, dp_mask, blink_mask, blank, lz_en,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode hex display driver: one digit per slot with
// dead-time, double-buffered frames, leading-zero suppression and blink.
module seven_seg_scan #(
    parameter int DIGITS    = 4,
    parameter int DIV       = 50000,
    parameter int DEAD      = 2,
    parameter int BLINK_DIV = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    seven_seg_scan_if.slave bus
);
    localparam int CW = $clog2(DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;
    logic [BW-1:0]       r_blink_cnt;
    logic                r_phase;
    logic [4*DIGITS-1:0] r_pend_value;
    logic [DIGITS-1:0]   r_pend_dp;
    logic [DIGITS-1:0]   r_pend_blink;
    logic                r_pend_valid;
    logic [4*DIGITS-1:0] r_act_value;
    logic [DIGITS-1:0]   r_act_dp;
    logic [DIGITS-1:0]   r_act_blink;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame_done;

    logic                w_slot_end;
    logic                w_frame_end;
    logic [3:0]          w_digit [DIGITS];
    logic [DIGITS-1:0]   w_nz;
    logic [DIGITS-1:0]   w_upper_zero;
    logic                w_suppress;
    logic                w_visible;
    logic [6:0]          w_seg_next;
    logic                w_dp_next;
    logic [DIGITS-1:0]   w_an_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h18;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign w_slot_end  = (r_presc == CW'(DIV - 1));
    assign w_frame_end = w_slot_end && (r_idx == IW'(DIGITS - 1));

    // Scan counters keep running while blanked so the frame cadence never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (w_frame_end) begin
                if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    // A load on the frame boundary lands in pending; the transfer takes the old pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_value <= '0;
            r_pend_dp    <= '0;
            r_pend_blink <= '0;
            r_pend_valid <= 1'b0;
            r_act_value  <= '0;
            r_act_dp     <= '0;
            r_act_blink  <= '0;
        end else begin
            if (w_frame_end && r_pend_valid) begin
                r_act_value <= r_pend_value;
                r_act_dp    <= r_pend_dp;
                r_act_blink <= r_pend_blink;
            end
            if (bus.load) begin
                r_pend_value <= bus.value;
                r_pend_dp    <= bus.dp_mask;
                r_pend_blink <= bus.blink_mask;
                r_pend_valid <= 1'b1;
            end else if (w_frame_end) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_digit[gi]      = r_act_value[4*gi +: 4];
            assign w_nz[gi]         = |r_act_value[4*gi +: 4];
            assign w_upper_zero[gi] = ((w_nz >> gi) == '0);
        end
    endgenerate

    assign w_suppress = bus.lz_en && (r_idx != '0) && w_upper_zero[r_idx];
    // A suppressed digit keeps its anode only to carry a lit decimal point.
    assign w_visible  = (r_presc >= CW'(DEAD)) && !bus.blank
                        && !(r_phase && r_act_blink[r_idx])
                        && !(w_suppress && !r_act_dp[r_idx]);

    always_comb begin
        w_seg_next = 7'h7F;
        w_dp_next  = 1'b1;
        w_an_next  = '1;
        if (w_visible) begin
            w_an_next  = ~(DIGITS'(1) << r_idx);
            w_seg_next = w_suppress ? 7'h7F : hex_to_seg(w_digit[r_idx]);
            w_dp_next  = ~r_act_dp[r_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_next;
            r_dp         <= w_dp_next;
            r_an         <= w_an_next;
            r_frame_done <= w_frame_end;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: scan timing, double buffering,
// leading-zero suppression, blink and asynchronous reset against a frame-level model.
module tb_seven_seg_scan;
    localparam int DIGITS    = 4;
    localparam int DIV       = 4;
    localparam int DEAD      = 1;
    localparam int BLINK_DIV = 2;
    localparam int FL        = DIGITS * DIV;
    localparam logic [12:0] RESET_OBS = {7'h7F, 1'b1, 4'hF, 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    seven_seg_scan_if #(.DIGITS(DIGITS)) bus ();

    seven_seg_scan #(
        .DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: edges since reset release plus the two frame buffers.
    int          cyc;
    logic [15:0] m_act_val, m_pend_val;
    logic [3:0]  m_act_dp, m_act_bm, m_pend_dp, m_pend_bm;
    logic        m_pend_valid;
    logic [12:0] exp_obs;
    logic [12:0] dut_obs;

    assign dut_obs = {bus.seg, bus.dp, bus.an, bus.frame_done};

    function automatic logic [12:0] model_expect();
        int          pos, p, idx, ph;
        logic [15:0] upper;
        logic        supp, vis;
        logic [12:0] r;
        pos   = cyc % FL;
        p     = pos % DIV;
        idx   = pos / DIV;
        ph    = ((cyc / FL) / BLINK_DIV) % 2;
        upper = m_act_val >> (4 * idx);
        supp  = bus.lz_en && (idx != 0) && (upper == 16'h0);
        vis   = (p >= DEAD) && !bus.blank && !(ph == 1 && m_act_bm[idx])
                && !(supp && !m_act_dp[idx]);
        r = RESET_OBS;
        if (vis)
            r = {supp ? 7'h7F : seg_tab[upper[3:0]], ~m_act_dp[idx], 4'hF & ~(4'b1 << idx), 1'b0};
        r[0] = (pos == FL - 1);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc          <= 0;
            m_act_val    <= '0;
            m_act_dp     <= '0;
            m_act_bm     <= '0;
            m_pend_val   <= '0;
            m_pend_dp    <= '0;
            m_pend_bm    <= '0;
            m_pend_valid <= 1'b0;
            exp_obs      <= RESET_OBS;
        end else begin
            exp_obs <= model_expect();
            if ((cyc % FL) == FL - 1 && m_pend_valid) begin
                m_act_val <= m_pend_val;
                m_act_dp  <= m_pend_dp;
                m_act_bm  <= m_pend_bm;
            end
            if (bus.load) begin
                m_pend_val   <= bus.value;
                m_pend_dp    <= bus.dp_mask;
                m_pend_bm    <= bus.blink_mask;
                m_pend_valid <= 1'b1;
            end else if ((cyc % FL) == FL - 1) begin
                m_pend_valid <= 1'b0;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL reset obs=%h exp=%h", dut_obs, RESET_OBS);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int fd_cnt = 0;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            n_checks++;
            if (dut_obs !== exp_obs) begin
                n_fail++;
                $display("FAIL scan cyc=%0d obs=%h exp=%h", cyc, dut_obs, exp_obs);
            end
            if (bus.frame_done) fd_cnt++;
        end
        n_checks++;
        if (fd_cnt !== 3) begin
            n_fail++;
            $display("FAIL scan_frame_count got=%0d exp=3", fd_cnt);
        end
    endtask

    task automatic test_load();
        bus.value = 16'h12AF;
        bus.load  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.load = 1'b0;
            n_checks++;
            if (dut_obs !== exp_obs) begin
                n_fail++;
                $display("FAIL load cyc=%0d obs=%h exp=%h", cyc, dut_obs, exp_obs);
            end
        end
    endtask

    task automatic test_lz();
        bus.lz_en   = 1'b1;
        bus.value   = 16'h0005;
        bus.dp_mask = 4'b0100;
        bus.load    = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.load = 1'b0;
            n_checks++;
            if (dut_obs !== exp_obs) begin
                n_fail++;
                $display("FAIL lz cyc=%0d obs=%h exp=%h", cyc, dut_obs, exp_obs);
            end
        end
    endtask

    task automatic test_blink();
        bus.lz_en      = 1'b0;
        bus.value      = 16'h8421;
        bus.dp_mask    = 4'b0001;
        bus.blink_mask = 4'b0001;
        bus.load       = 1'b1;
        for (int k = 0; k < 96; k++) begin
            @(negedge clk);
            bus.load = 1'b0;
            n_checks++;
            if (dut_obs !== exp_obs) begin
                n_fail++;
                $display("FAIL blink cyc=%0d obs=%h exp=%h", cyc, dut_obs, exp_obs);
            end
        end
    endtask

    task automatic test_back_to_back();
        int waited = 0;
        bus.blink_mask = 4'b0000;
        bus.dp_mask    = 4'b0000;
        bus.value      = 16'h3C00;
        bus.load       = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        while ((cyc % FL) != FL - 1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if ((cyc % FL) != FL - 1) begin
            n_fail++;
            $display("FAIL b2b_align cyc=%0d exp_pos=%0d", cyc, FL - 1);
        end
        bus.value = 16'hBEEF;
        bus.load  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.load = 1'b0;
            n_checks++;
            if (dut_obs !== exp_obs) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d obs=%h exp=%h", cyc, dut_obs, exp_obs);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 240; k++) begin
            @(negedge clk);
            n_checks++;
            if (dut_obs !== exp_obs) begin
                n_fail++;
                $display("FAIL random cyc=%0d obs=%h exp=%h", cyc, dut_obs, exp_obs);
            end
            bus.load = ($urandom_range(7) == 0);
            if (bus.load) begin
                bus.value      = 16'($urandom_range(3) == 0 ? $urandom_range(15) : $urandom);
                bus.dp_mask    = 4'($urandom);
                bus.blink_mask = 4'($urandom);
            end
            bus.blank = ($urandom_range(9) == 0);
            if (k % 16 == 0) bus.lz_en = 1'($urandom_range(1));
        end
        bus.load  = 1'b0;
        bus.blank = 1'b0;
    endtask

    task automatic test_async_reset();
        int waited = 0;
        bus.lz_en      = 1'b0;
        bus.blink_mask = 4'b0000;
        bus.value      = 16'h7777;
        bus.load       = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        while ((cyc % FL) != 9 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL async_reset obs=%h exp=%h", dut_obs, RESET_OBS);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_checks++;
            if (dut_obs !== exp_obs) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d obs=%h exp=%h", cyc, dut_obs, exp_obs);
            end
            if (k == 1) begin
                n_checks++;
                if (bus.an !== 4'b1110 || bus.seg !== 7'h40) begin
                    n_fail++;
                    $display("FAIL restart an=%b seg=%h exp an=1110 seg=40", bus.an, bus.seg);
                end
            end
        end
    endtask

    initial begin
        bus.value      = '0;
        bus.load       = 1'b0;
        bus.dp_mask    = '0;
        bus.blink_mask = '0;
        bus.blank      = 1'b0;
        bus.lz_en      = 1'b0;
        test_reset();
        test_scan();
        test_load();
        test_lz();
        test_blink();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
